// File: rtl/dual_issue_queue.sv
// Purpose : instruction issue buffer between fetch and dual-issue decode; circular
//           store that accepts up to two instructions per cycle and exposes the two oldest.
// Latency : one cycle from push to visibility on slot A/B; the outputs are combinational
//           from head/head+1, with no bypass on an empty queue.
// Backpr. : in_ready = at least 2 free entries, taken from the pre-pop count. A push while
//           !in_ready is dropped. Retire is 0/1/2 per cycle, gated by stall and super_scalar.
//
// Ports:
//   clk, rst_n                        clock, async active-low reset
//   flush                             discard all entries (redirect); overrides push/pop
//   in_valid_a/b, in_instr_a/b,
//   in_pc4_a/b, in_ready              fetch side, A older than B
//   stall, super_scalar               decode retire control
//   out_valid_a/b, out_instr_a/b,
//   out_pc4_a/b                       head / head+1 entries, zeroed when invalid
//   count                             occupied entries
module dual_issue_queue #(
    parameter int DEPTH = 8,
    parameter int W     = 32
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         flush,
    input  logic                         in_valid_a,
    input  logic [W-1:0]                 in_instr_a,
    input  logic [W-1:0]                 in_pc4_a,
    input  logic                         in_valid_b,
    input  logic [W-1:0]                 in_instr_b,
    input  logic [W-1:0]                 in_pc4_b,
    output logic                         in_ready,
    input  logic                         stall,
    input  logic                         super_scalar,
    output logic                         out_valid_a,
    output logic [W-1:0]                 out_instr_a,
    output logic [W-1:0]                 out_pc4_a,
    output logic                         out_valid_b,
    output logic [W-1:0]                 out_instr_b,
    output logic [W-1:0]                 out_pc4_b,
    output logic [$clog2(DEPTH+1)-1:0]   count
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH+1);

    logic [W-1:0]  instr_q [DEPTH];
    logic [W-1:0]  instr_d [DEPTH];
    logic [W-1:0]  pc4_q   [DEPTH];
    logic [W-1:0]  pc4_d   [DEPTH];
    logic [PW-1:0] head_q, head_d;
    logic [PW-1:0] tail_q, tail_d;
    logic [CW-1:0] count_q, count_d;

    logic [PW-1:0] head1;
    logic [PW-1:0] tail1;
    logic [1:0]    pop_cnt;
    logic [1:0]    push_cnt;

    // Pointers are PW bits wide and DEPTH is a power of two, so the +1
    // wraps DEPTH-1 -> 0 on its own. This keeps head+1 in order across the wrap.
    assign head1 = head_q + 1'b1;
    assign tail1 = tail_q + 1'b1;

    always_comb begin
        out_valid_a = (count_q != '0);
        out_valid_b = (count_q >= CW'(2));
        out_instr_a = out_valid_a ? instr_q[head_q] : '0;
        out_pc4_a   = out_valid_a ? pc4_q[head_q]   : '0;
        out_instr_b = out_valid_b ? instr_q[head1]  : '0;
        out_pc4_b   = out_valid_b ? pc4_q[head1]    : '0;
        count       = count_q;
        // Readiness comes from the pre-pop count, so it never depends on
        // the retire decision made in the same cycle.
        in_ready    = (count_q <= CW'(DEPTH - 2));
    end

    always_comb begin
        pop_cnt = 2'd0;
        if (!stall && out_valid_a) begin
            // super_scalar has no effect while slot B is empty.
            pop_cnt = (out_valid_b && super_scalar) ? 2'd2 : 2'd1;
        end

        push_cnt = 2'd0;
        if (in_ready) begin
            push_cnt = {1'b0, in_valid_a} + {1'b0, in_valid_b};
        end

        instr_d = instr_q;
        pc4_d   = pc4_q;
        if (in_ready && !flush) begin
            if (in_valid_a) begin
                instr_d[tail_q] = in_instr_a;
                pc4_d[tail_q]   = in_pc4_a;
                if (in_valid_b) begin
                    instr_d[tail1] = in_instr_b;
                    pc4_d[tail1]   = in_pc4_b;
                end
            end else if (in_valid_b) begin
                // A lone slot-B instruction is packed at the tail.
                instr_d[tail_q] = in_instr_b;
                pc4_d[tail_q]   = in_pc4_b;
            end
        end

        head_d  = head_q + PW'(pop_cnt);
        tail_d  = tail_q + PW'(push_cnt);
        count_d = count_q + CW'(push_cnt) - CW'(pop_cnt);

        if (flush) begin
            head_d  = '0;
            tail_d  = '0;
            count_d = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                instr_q[i] <= '0;
                pc4_q[i]   <= '0;
            end
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
            instr_q <= instr_d;
            pc4_q   <= pc4_d;
        end
    end

endmodule

// File: tb/tb_dual_issue_queue.sv
// Purpose : self-checking bench for dual_issue_queue. A queue of expected entries
//           is filled as pushes are driven and drained as the DUT retires.
// Latency : outputs are sampled 1 time unit after each rising edge.
// Backpr. : acceptance of a push is predicted from the expected occupancy.
module tb_dual_issue_queue;

    localparam int DEPTH = 8;
    localparam int W     = 32;

    typedef struct {
        logic [W-1:0] instr;
        logic [W-1:0] pc4;
    } ent_t;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          flush;
    logic          in_valid_a, in_valid_b;
    logic [W-1:0]  in_instr_a, in_pc4_a, in_instr_b, in_pc4_b;
    logic          in_ready;
    logic          stall, super_scalar;
    logic          out_valid_a, out_valid_b;
    logic [W-1:0]  out_instr_a, out_pc4_a, out_instr_b, out_pc4_b;
    logic [3:0]    count;

    ent_t sb[$];
    int   n_vec = 0;
    int   n_err = 0;
    int   seq   = 1;

    always #5 clk = ~clk;

    dual_issue_queue #(.DEPTH(DEPTH), .W(W)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .flush        (flush),
        .in_valid_a   (in_valid_a),
        .in_instr_a   (in_instr_a),
        .in_pc4_a     (in_pc4_a),
        .in_valid_b   (in_valid_b),
        .in_instr_b   (in_instr_b),
        .in_pc4_b     (in_pc4_b),
        .in_ready     (in_ready),
        .stall        (stall),
        .super_scalar (super_scalar),
        .out_valid_a  (out_valid_a),
        .out_instr_a  (out_instr_a),
        .out_pc4_a    (out_pc4_a),
        .out_valid_b  (out_valid_b),
        .out_instr_b  (out_instr_b),
        .out_pc4_b    (out_pc4_b),
        .count        (count)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic check_outputs();
        int n;
        n = sb.size();
        chk("count",    32'(count),       32'(n));
        chk("in_ready", 32'(in_ready),    32'(n <= DEPTH - 2));
        chk("valid_a",  32'(out_valid_a), 32'(n >= 1));
        chk("valid_b",  32'(out_valid_b), 32'(n >= 2));
        chk("instr_a",  out_instr_a, (n >= 1) ? sb[0].instr : 32'h0);
        chk("pc4_a",    out_pc4_a,   (n >= 1) ? sb[0].pc4   : 32'h0);
        chk("instr_b",  out_instr_b, (n >= 2) ? sb[1].instr : 32'h0);
        chk("pc4_b",    out_pc4_b,   (n >= 2) ? sb[1].pc4   : 32'h0);
    endtask

    // Applies one cycle of stimulus. The model updates the expected queue
    // and the DUT is compared after the edge.
    task automatic cyc(input bit va, input bit vb, input bit st, input bit ss, input bit fl);
        bit rdy;
        int pops;
        in_valid_a   = va;
        in_instr_a   = {16'h2008, 16'(seq)};
        in_pc4_a     = 32'h0001_0000 + 32'(seq) * 4;
        in_valid_b   = vb;
        in_instr_b   = {16'h2009, 16'(seq + 1)};
        in_pc4_b     = 32'h0001_0000 + 32'(seq + 1) * 4;
        stall        = st;
        super_scalar = ss;
        flush        = fl;
        seq          = seq + 2;

        rdy  = (sb.size() <= DEPTH - 2);
        pops = (st || sb.size() == 0) ? 0 : ((sb.size() >= 2 && ss) ? 2 : 1);
        if (fl) begin
            sb.delete();
        end else begin
            repeat (pops) sb.delete(0);
            if (rdy && va) sb.push_back('{in_instr_a, in_pc4_a});
            if (rdy && vb) sb.push_back('{in_instr_b, in_pc4_b});
        end
        @(posedge clk);
        #1;
        check_outputs();
    endtask

    initial begin
        rst_n = 1'b0; flush = 1'b0; stall = 1'b0; super_scalar = 1'b0;
        in_valid_a = 1'b0; in_valid_b = 1'b0;
        in_instr_a = '0; in_pc4_a = '0; in_instr_b = '0; in_pc4_b = '0;
        #12;
        check_outputs();                 // reset state
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Push one pair, then hold it under stall; both slots become visible.
        cyc(1, 1, 1, 0, 0);
        chk("t1_instr_a", out_instr_a, 32'h2008_0001);
        chk("t1_instr_b", out_instr_b, 32'h2009_0002);
        cyc(0, 0, 1, 0, 0);
        // Dual retire empties the queue.
        cyc(0, 0, 0, 1, 0);
        chk("t2_empty", 32'(count), 32'd0);

        // Three entries, then single retire over three cycles.
        cyc(1, 1, 1, 0, 0);
        cyc(1, 0, 1, 0, 0);
        repeat (3) cyc(0, 0, 0, 0, 0);

        // Fill at 2 per cycle under stall; the extra pushes are dropped.
        repeat (6) cyc(1, 1, 1, 0, 0);
        chk("full_count", 32'(count), 32'(DEPTH));
        chk("full_rdy",   32'(in_ready), 32'd0);

        // Head is at 5. Two single retires move it to 7, then a dual issue spans 7 -> 0.
        repeat (2) cyc(0, 0, 0, 0, 0);
        cyc(0, 0, 0, 1, 0);
        repeat (4) cyc(0, 0, 0, 1, 0);

        // Mixed random traffic with occasional flushes.
        for (int i = 0; i < 300; i++) begin
            cyc(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                1'($urandom_range(0, 3) == 0), 1'($urandom_range(0, 1)),
                1'($urandom_range(0, 31) == 0));
        end

        // Flush with a simultaneous push and pop.
        cyc(1, 1, 1, 0, 0);
        cyc(1, 1, 1, 0, 0);
        cyc(1, 1, 0, 1, 1);
        chk("flush_count", 32'(count), 32'd0);
        cyc(1, 0, 1, 0, 0);

        // An asynchronous reset in mid-stream clears the outputs before any clock edge.
        cyc(1, 1, 1, 0, 0);
        in_valid_a = 1'b0; in_valid_b = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        sb.delete();
        check_outputs();
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check_outputs();
        cyc(1, 1, 0, 1, 0);
        cyc(0, 0, 0, 1, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
